// File: rtl/uart_mmio_ctrl.sv
// Purpose: memory-mapped UART controller; CPU pushes TX bytes and polls/pops RX bytes.
// Latency: reads return in dout one cycle after re && !stall; pushes/pops land on that same edge.
// Backpressure: TX drains on uart_din_ready; full TX drops the byte (tx_drop); full RX drops (rx_ovf).
//
// Ports:
//   clk, rst                      CPU clock, asynchronous active-high reset
//   addr, we, re, din, stall      CPU data-memory bus; nothing commits while stall is high
//   dout                          registered read data
//   uart_din, uart_din_valid      TX byte to the UART core, qualified by uart_din_ready
//   uart_dout, uart_dout_valid    RX byte from the UART core, accepted while uart_dout_ready
// Optional feature: define UART_MMIO_CYCLE_COUNTER_EN for the cycle counter at 0x80000010.

// Small circular-buffer FIFO; head is visible combinationally, full pushes and empty pops are ignored.
// Latency: a push is visible at the head on the edge after it is accepted.
// Backpressure: none internally; callers read cnt to decide flow control.
module uart_mmio_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [W-1:0]            push_dat,
    input  logic                    pop,
    output logic [W-1:0]            head_dat,
    output logic [$clog2(DEPTH):0]  cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Full/empty come from the pre-edge count, so a push into a full FIFO is
    // rejected even when a pop frees a slot on the same edge.
    assign push_ok  = push && (cnt != FULL_CNT);
    assign pop_ok   = pop && (cnt != '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end
endmodule

module uart_mmio_ctrl #(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] din,
    input  logic        stall,
    output logic [31:0] dout,
    output logic [7:0]  uart_din,
    output logic        uart_din_valid,
    input  logic        uart_din_ready,
    input  logic [7:0]  uart_dout,
    input  logic        uart_dout_valid,
    output logic        uart_dout_ready
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [TAW:0] TX_FULL_CNT = (TAW+1)'(TX_DEPTH);
    localparam logic [RAW:0] RX_FULL_CNT = (RAW+1)'(RX_DEPTH);

    localparam logic [4:0] OFF_RX_CTRL = 5'h00;
    localparam logic [4:0] OFF_RX_DATA = 5'h04;
    localparam logic [4:0] OFF_TX_CTRL = 5'h08;
    localparam logic [4:0] OFF_TX_DATA = 5'h0C;
    localparam logic [4:0] OFF_CYCLE   = 5'h10;

    logic         sel;
    logic         rd_any;
    logic         rd_sel;
    logic         wr_sel;
    logic [4:0]   off;
    logic [TAW:0] tx_cnt;
    logic [RAW:0] rx_cnt;
    logic [7:0]   tx_head;
    logic [7:0]   rx_head;
    logic         tx_full;
    logic         rx_full;
    logic         rx_nonempty;
    logic         tx_wr;
    logic         tx_pop;
    logic         rx_push;
    logic         rx_pop;
    logic         rx_ovf;
    logic         tx_drop;
    logic [31:0]  rdata;
    logic         unused_din;

    assign sel    = (addr[31:28] == 4'h8) && (addr[27:5] == '0);
    assign off    = addr[4:0];
    assign rd_any = re && !stall;
    assign rd_sel = rd_any && sel;
    assign wr_sel = sel && (|we) && !stall;

    assign tx_full     = (tx_cnt == TX_FULL_CNT);
    assign rx_full     = (rx_cnt == RX_FULL_CNT);
    assign rx_nonempty = (rx_cnt != '0);

    // Only byte lane 0 carries TX data.
    assign tx_wr  = wr_sel && (off == OFF_TX_DATA) && we[0];
    assign rx_pop = rd_sel && (off == OFF_RX_DATA) && rx_nonempty;

    assign uart_dout_ready = ~rst;
    assign rx_push         = uart_dout_valid && uart_dout_ready;
    assign uart_din_valid  = (tx_cnt != '0);
    assign uart_din        = uart_din_valid ? tx_head : 8'h00;
    assign tx_pop          = uart_din_valid && uart_din_ready;

    assign unused_din = ^din[31:8];

    uart_mmio_fifo #(.DEPTH(TX_DEPTH), .W(8)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_wr),
        .push_dat (din[7:0]),
        .pop      (tx_pop),
        .head_dat (tx_head),
        .cnt      (tx_cnt)
    );

    uart_mmio_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_push),
        .push_dat (uart_dout),
        .pop      (rx_pop),
        .head_dat (rx_head),
        .cnt      (rx_cnt)
    );

    // Sticky error flags: a drop on the same edge as a clearing write wins,
    // so a lost byte is never silently hidden.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ovf  <= 1'b0;
            tx_drop <= 1'b0;
        end else begin
            if (rx_push && rx_full)
                rx_ovf <= 1'b1;
            else if (wr_sel && (off == OFF_RX_CTRL))
                rx_ovf <= 1'b0;
            if (tx_wr && tx_full)
                tx_drop <= 1'b1;
            else if (wr_sel && (off == OFF_TX_CTRL))
                tx_drop <= 1'b0;
        end
    end

`ifdef UART_MMIO_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cycle_cnt <= '0;
        else if (wr_sel && (off == OFF_CYCLE))
            cycle_cnt <= '0;
        else
            cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

    always_comb begin
        rdata = 32'h0;
        if (sel) begin
            case (off)
                OFF_RX_CTRL: rdata = {30'h0, rx_ovf, rx_nonempty};
                OFF_RX_DATA: rdata = rx_nonempty ? {24'h0, rx_head} : 32'h0;
                OFF_TX_CTRL: rdata = {30'h0, tx_drop, ~tx_full};
`ifdef UART_MMIO_CYCLE_COUNTER_EN
                OFF_CYCLE:   rdata = cycle_cnt;
`endif
                default:     rdata = 32'h0;
            endcase
        end
    end

    // Unselected reads still load 0; dout holds whenever no read commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dout <= 32'h0;
        else if (rd_any)
            dout <= rdata;
    end
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Bench for uart_mmio_ctrl: directed table of CPU accesses, hand-written corner
// sequences, then randomized traffic checked against a queue-based model.
module tb_uart_mmio_ctrl;
    localparam int TXD = 8;
    localparam int RXD = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [3:0]  we = 4'h0;
    logic        re = 1'b0;
    logic [31:0] din = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] dout;
    logic [7:0]  uart_din;
    logic        uart_din_valid;
    logic        uart_din_ready = 1'b0;
    logic [7:0]  uart_dout = 8'h0;
    logic        uart_dout_valid = 1'b0;
    logic        uart_dout_ready;

    int n_chk  = 0;
    int n_pass = 0;

    uart_mmio_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
        .clk             (clk),
        .rst             (rst),
        .addr            (addr),
        .we              (we),
        .re              (re),
        .din             (din),
        .stall           (stall),
        .dout            (dout),
        .uart_din        (uart_din),
        .uart_din_valid  (uart_din_valid),
        .uart_din_ready  (uart_din_ready),
        .uart_dout       (uart_dout),
        .uart_dout_valid (uart_dout_valid),
        .uart_dout_ready (uart_dout_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  w;
        logic [31:0] d;
        logic        r;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Reference model state
    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic        m_ovf;
    logic        m_drop;
    logic [31:0] m_dout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        addr = a; din = d; we = w;
        cyc();
        we = 4'h0;
    endtask

    task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a; re = 1'b1;
        cyc();
        re = 1'b0;
        chk(name, dout, exp);
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a, input int rxn, input int txn);
        case (a)
            32'h80000000: return {30'h0, m_ovf, rxn != 0};
            32'h80000004: return (rxn != 0) ? {24'h0, rxq[0]} : 32'h0;
            32'h80000008: return {30'h0, m_drop, txn != TXD};
            default:      return 32'h0;
        endcase
    endfunction

    initial begin
        logic [31:0] junk_addr [4];
        junk_addr[0] = 32'h90000004;
        junk_addr[1] = 32'h80000020;
        junk_addr[2] = 32'h80000014;
        junk_addr[3] = 32'h8000000C;

        // ---- Reset state ----
        cyc(); cyc();
        chk("rst_dout", dout, 32'h0);
        chk("rst_din_valid", {31'h0, uart_din_valid}, 32'h0);
        chk("rst_uart_din", {24'h0, uart_din}, 32'h0);
        chk("rst_dout_ready", {31'h0, uart_dout_ready}, 32'h0);
        rst = 1'b0;
        cyc();
        chk("post_rst_dout_ready", {31'h0, uart_dout_ready}, 32'h1);
        rdchk("tx_ctrl_after_rst", 32'h80000008, 32'h1);
        chk("tx_valid_after_rst", {31'h0, uart_din_valid}, 32'h0);

        // ---- TX ordering with ready low then one-cycle ready ----
        wr(32'h8000000C, 32'h41, 4'h1);
        wr(32'h8000000C, 32'h42, 4'h1);
        chk("tx_head_41", {24'h0, uart_din}, 32'h41);
        chk("tx_valid_1", {31'h0, uart_din_valid}, 32'h1);
        uart_din_ready = 1'b1; cyc(); uart_din_ready = 1'b0;
        chk("tx_head_42", {24'h0, uart_din}, 32'h42);
        uart_din_ready = 1'b1; cyc(); uart_din_ready = 1'b0;
        chk("tx_empty", {31'h0, uart_din_valid}, 32'h0);

        // ---- RX fill past depth, then table-driven read-out ----
        for (int i = 0; i < 9; i++) begin
            uart_dout = 8'h10 + 8'(i); uart_dout_valid = 1'b1;
            cyc();
        end
        uart_dout_valid = 1'b0;

        tbl.push_back('{32'h80000000, 4'h0, 32'h0, 1'b1, 32'h3});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{32'h80000004, 4'h0, 32'h0, 1'b1, 32'h10 + i});
        tbl.push_back('{32'h80000004, 4'h0, 32'h0, 1'b1, 32'h0});
        tbl.push_back('{32'h80000000, 4'h0, 32'h0, 1'b1, 32'h2});
        tbl.push_back('{32'h80000000, 4'h1, 32'h0, 1'b0, 32'h0});
        tbl.push_back('{32'h80000000, 4'h0, 32'h0, 1'b1, 32'h0});
        tbl.push_back('{32'h8000000C, 4'h0, 32'h0, 1'b1, 32'h0});
        tbl.push_back('{32'h80000014, 4'h0, 32'h0, 1'b1, 32'h0});
        tbl.push_back('{32'h90000000, 4'h0, 32'h0, 1'b1, 32'h0});
        tbl.push_back('{32'h80000020, 4'h0, 32'h0, 1'b1, 32'h0});
        for (int i = 0; i < tbl.size(); i++) begin
            addr = tbl[i].a; we = tbl[i].w; din = tbl[i].d; re = tbl[i].r;
            cyc();
            we = 4'h0; re = 1'b0;
            if (tbl[i].r) chk($sformatf("tbl%0d", i), dout, tbl[i].exp);
        end

        // ---- TX full, drop, and full-with-simultaneous-pop ----
        for (int i = 0; i < 8; i++) wr(32'h8000000C, 32'h60 + i, 4'h1);
        wr(32'h8000000C, 32'hFF, 4'h1);
        rdchk("tx_full_drop", 32'h80000008, 32'h2);
        wr(32'h80000008, 32'h0, 4'hF);
        rdchk("tx_full_cleared", 32'h80000008, 32'h0);
        uart_din_ready = 1'b1;
        wr(32'h8000000C, 32'hEE, 4'h1);
        uart_din_ready = 1'b0;
        rdchk("tx_full_pop_reject", 32'h80000008, 32'h3);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("tx_drain%0d", i), {24'h0, uart_din}, 32'h60 + i);
            uart_din_ready = 1'b1; cyc(); uart_din_ready = 1'b0;
        end
        chk("tx_drained", {31'h0, uart_din_valid}, 32'h0);
        wr(32'h80000008, 32'h0, 4'h1);
        rdchk("tx_ctrl_clean", 32'h80000008, 32'h1);

        // ---- Stall holds dout and blocks the pop ----
        uart_dout = 8'h55; uart_dout_valid = 1'b1; cyc(); uart_dout_valid = 1'b0;
        stall = 1'b1; re = 1'b1; addr = 32'h80000004;
        repeat (3) cyc();
        chk("stall_hold", dout, 32'h1);
        stall = 1'b0;
        cyc();
        re = 1'b0;
        chk("stall_release", dout, 32'h55);
        rdchk("stall_popped_once", 32'h80000000, 32'h0);

        // ---- Pop of empty RX with simultaneous UART push ----
        uart_dout = 8'h77; uart_dout_valid = 1'b1; re = 1'b1; addr = 32'h80000004;
        cyc();
        uart_dout_valid = 1'b0; re = 1'b0;
        chk("empty_pop_push", dout, 32'h0);
        rdchk("empty_pop_kept", 32'h80000004, 32'h77);

        // ---- TX data write without we[0] ----
        wr(32'h8000000C, 32'h99, 4'hE);
        chk("tx_we0_ignored", {31'h0, uart_din_valid}, 32'h0);

        // ---- Reset mid-transfer ----
        for (int i = 0; i < 3; i++) wr(32'h8000000C, 32'hA0 + i, 4'h1);
        uart_dout = 8'h33; uart_dout_valid = 1'b1; cyc(); uart_dout_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_tx_empty", {31'h0, uart_din_valid}, 32'h0);
        chk("midrst_dout_ready", {31'h0, uart_dout_ready}, 32'h0);
        cyc();
        rst = 1'b0;
        rdchk("midrst_rx_empty", 32'h80000000, 32'h0);

        // ---- Cycle counter ----
        wr(32'h80000010, 32'h0, 4'hF);
        repeat (9) cyc();
`ifdef UART_MMIO_CYCLE_COUNTER_EN
        rdchk("cycle_cnt", 32'h80000010, 32'd9);
`else
        rdchk("cycle_cnt", 32'h80000010, 32'd0);
`endif

        // ---- Randomized traffic against the model ----
        rst = 1'b1; cyc(); rst = 1'b0;
        txq.delete(); rxq.delete();
        m_ovf = 1'b0; m_drop = 1'b0; m_dout = 32'h0;
        for (int n = 0; n < 2000; n++) begin
            int op;
            int rxn;
            int txn;
            bit hi;
            op  = int'($urandom % 6);
            hi  = ((n / 400) % 2) == 1;
            addr = 32'h0; we = 4'h0; re = 1'b0;
            din  = $urandom;
            stall = ($urandom % 4) == 0;
            uart_din_ready  = ($urandom % 4) < (hi ? 3 : 1);
            uart_dout_valid = ($urandom % 6) < (hi ? 1 : 3);
            uart_dout = 8'($urandom);
            case (op)
                0: begin addr = 32'h8000000C; we = (($urandom % 3) == 0) ? 4'h2 : 4'h1; end
                1: begin addr = 32'h80000004; re = 1'b1; end
                2: begin addr = 32'h80000000; re = 1'b1; end
                3: begin addr = 32'h80000008; re = 1'b1; end
                4: begin addr = (($urandom % 2) == 0) ? 32'h80000000 : 32'h80000008; we = 4'hF; end
                default: begin addr = junk_addr[$urandom % 4]; re = 1'b1; end
            endcase

            chk("rnd_din_valid", {31'h0, uart_din_valid}, {31'h0, txq.size() != 0});
            chk("rnd_uart_din", {24'h0, uart_din}, (txq.size() != 0) ? {24'h0, txq[0]} : 32'h0);

            rxn = rxq.size();
            txn = txq.size();
            if (!stall && re) m_dout = mread(addr, rxn, txn);
            if (!stall && re && addr == 32'h80000004 && rxn > 0) void'(rxq.pop_front());
            if (!stall && we != 4'h0 && addr == 32'h80000000) m_ovf = 1'b0;
            if (uart_dout_valid) begin
                if (rxn == RXD) m_ovf = 1'b1;
                else rxq.push_back(uart_dout);
            end
            if (uart_din_ready && txn > 0) void'(txq.pop_front());
            if (!stall && we != 4'h0 && addr == 32'h80000008) m_drop = 1'b0;
            if (!stall && we[0] && addr == 32'h8000000C) begin
                if (txn == TXD) m_drop = 1'b1;
                else txq.push_back(din[7:0]);
            end

            cyc();
            chk("rnd_dout", dout, m_dout);
        end
        we = 4'h0; re = 1'b0; stall = 1'b0; uart_dout_valid = 1'b0; uart_din_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
